// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the minimal SM83 core.
//   - T-state / M-cycle enums
//   - r-field register indices (B,C,D,E,H,L,(HL),A)
//   - ALU op codes (opcode bits [5:3] of 0x80-0xBF) and flag bit positions
//   - alu8(): combinational 8-bit ALU returning result plus full F byte
package cpu_pkg;

  typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} tstate_e;
  typedef enum logic       {M1 = 1'b0, M2 = 1'b1} mcyc_e;

  localparam logic [2:0] R_B  = 3'd0;
  localparam logic [2:0] R_C  = 3'd1;
  localparam logic [2:0] R_D  = 3'd2;
  localparam logic [2:0] R_E  = 3'd3;
  localparam logic [2:0] R_H  = 3'd4;
  localparam logic [2:0] R_L  = 3'd5;
  localparam logic [2:0] R_HL = 3'd6;
  localparam logic [2:0] R_A  = 3'd7;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_ADC = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_SBC = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_OR  = 3'd6;
  localparam logic [2:0] ALU_CP  = 3'd7;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] res;
  } alu_out_t;

  // Subtractions run one bit wider so the top bit is the borrow out
  // (full byte) or the half borrow (low nibble).
  function automatic alu_out_t alu8(input logic [2:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic cin);
    alu_out_t   o;
    logic [8:0] sum;
    logic [4:0] hs;
    logic       c;
    o   = '0;
    sum = '0;
    hs  = '0;
    c   = (op == ALU_ADC || op == ALU_SBC) ? cin : 1'b0;
    case (op)
      ALU_ADD, ALU_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {8'd0, c};
        hs  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c};
        o.res = sum[7:0];
        o.f[FLAG_H] = hs[4];
        o.f[FLAG_C] = sum[8];
      end
      ALU_SUB, ALU_SBC, ALU_CP: begin
        sum = {1'b0, a} - {1'b0, b} - {8'd0, c};
        hs  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, c};
        o.res = sum[7:0];
        o.f[FLAG_N] = 1'b1;
        o.f[FLAG_H] = hs[4];
        o.f[FLAG_C] = sum[8];
      end
      ALU_AND: begin
        o.res = a & b;
        o.f[FLAG_H] = 1'b1;
      end
      ALU_XOR: o.res = a ^ b;
      default: o.res = a | b;
    endcase
    o.f[FLAG_Z] = (o.res == 8'h00);
    return o;
  endfunction

endpackage

// File: rtl/cpu_top_mem.sv
// cpu_top_mem: read-only program memory, 2**MEM_AW bytes, combinational read.
//   addr[MEM_AW-1:0] -> rdata[7:0]
// Contents of mem[] are loaded by the simulation environment.
module cpu_top_mem #(
  parameter int MEM_AW = 8
) (
  input  logic [MEM_AW-1:0] addr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [0:2**MEM_AW-1];

  assign rdata = mem[addr];
endmodule

// File: rtl/cpu_top_regfile.sv
// reg8: one 8-bit register cell with write enable.
//   clk, rst (async, active low), we, d[7:0] -> data_out[7:0]
// regfile: the seven SM83 8-bit registers as reg8 instances a,b,c,d,e,h,l.
//   clk, rst, we, waddr[2:0] (r-field index), wdata[7:0]
//   regs[7:0][7:0]: all registers indexed by r field; index 6 ((HL)) reads 0.
module reg8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] data_out
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    data_out <= 8'h00;
    else if (we) data_out <= d;
  end
endmodule

module regfile
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [2:0]      waddr,
  input  logic [7:0]      wdata,
  output logic [7:0][7:0] regs
);
  reg8 b (.clk(clk), .rst(rst), .we(we && waddr == R_B), .d(wdata), .data_out(regs[R_B]));
  reg8 c (.clk(clk), .rst(rst), .we(we && waddr == R_C), .d(wdata), .data_out(regs[R_C]));
  reg8 d (.clk(clk), .rst(rst), .we(we && waddr == R_D), .d(wdata), .data_out(regs[R_D]));
  reg8 e (.clk(clk), .rst(rst), .we(we && waddr == R_E), .d(wdata), .data_out(regs[R_E]));
  reg8 h (.clk(clk), .rst(rst), .we(we && waddr == R_H), .d(wdata), .data_out(regs[R_H]));
  reg8 l (.clk(clk), .rst(rst), .we(we && waddr == R_L), .d(wdata), .data_out(regs[R_L]));
  reg8 a (.clk(clk), .rst(rst), .we(we && waddr == R_A), .d(wdata), .data_out(regs[R_A]));

  // (HL) is not a real register here; the top never writes it.
  assign regs[R_HL] = 8'h00;
endmodule

// File: rtl/cpu_top.sv
// cpu_top: minimal SM83 core (register-only subset) with internal program memory.
//   clk            system clock, all state on posedge
//   rst            asynchronous active-low reset
//   testing_data   debug operand for opcode 0xD3 (only with DEBUG_PORT_EN)
//   data_out[7:0]  byte fetched from memory, registered at T2
//   rd             memory read strobe (high T1..T3 of each fetch / operand read)
//   addr_bus[15:0] current bus address
// Optional feature: define DEBUG_PORT_EN to make 0xD3 load testing_data into A.
// Each M-cycle is T1..T4; registers and flags are written on the T3->T4 edge.
module cpu_top
  import cpu_pkg::*;
#(
  parameter int          MEM_AW = 8,
  parameter logic [15:0] PC_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  testing_data,
  output logic [7:0]  data_out,
  output logic        rd,
  output logic [15:0] addr_bus
);

  tstate_e         tstate_q, tstate_d;
  mcyc_e           mcyc_q, mcyc_d;
  logic [15:0]     pc_q, pc_d, addr_q, addr_d;
  logic [7:0]      opcode_q, opcode_d, imm_q, imm_d, flag_q, flag_d, dout_q, dout_d;
  logic            halt_q, halt_d, rd_q, rd_d;
  logic            m1t1;

  logic [7:0][7:0] regs;
  logic            rf_we;
  logic [2:0]      rf_waddr;
  logic [7:0]      rf_wdata;
  logic [7:0]      mem_rdata;

  logic [2:0]      src, dst;
  logic [7:0]      src_v, dst_v, incdec_v;
  logic            is_ldn;
  alu_out_t        alu_r;

  regfile r1 (.clk(clk), .rst(rst), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata), .regs(regs));

  cpu_top_mem #(.MEM_AW(MEM_AW)) mem (.addr(pc_q[MEM_AW-1:0]), .rdata(mem_rdata));

  assign m1t1     = (tstate_q == T1) && (mcyc_q == M1) && !halt_q;
  assign data_out = dout_q;
  assign rd       = rd_q;
  assign addr_bus = addr_q;

  assign src      = opcode_q[2:0];
  assign dst      = opcode_q[5:3];
  assign src_v    = regs[src];
  assign dst_v    = regs[dst];
  assign is_ldn   = (opcode_q[7:6] == 2'b00) && (src == R_HL) && (dst != R_HL);
  assign alu_r    = alu8(dst, regs[R_A], src_v, flag_q[FLAG_C]);
  assign incdec_v = opcode_q[0] ? dst_v - 8'd1 : dst_v + 8'd1;

`ifndef DEBUG_PORT_EN
  logic unused_testing_data;
  assign unused_testing_data = ^testing_data;
`endif

  always_comb begin
    tstate_d = tstate_q;
    mcyc_d   = mcyc_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    flag_d   = flag_q;
    dout_d   = dout_q;
    halt_d   = halt_q;
    rd_d     = rd_q;
    rf_we    = 1'b0;
    rf_waddr = R_A;
    rf_wdata = 8'h00;
    // Once halted everything freezes until reset.
    if (!halt_q) begin
      tstate_d = tstate_e'(tstate_q + 2'd1);
      case (tstate_q)
        T1: begin
          dout_d = mem_rdata;
          pc_d   = pc_q + 16'd1;
          if (m1t1) opcode_d = mem_rdata;
          else      imm_d    = mem_rdata;
        end
        T3: begin
          rd_d = 1'b0;
          if (mcyc_q == M2) begin
            rf_we    = 1'b1;
            rf_waddr = dst;
            rf_wdata = imm_q;
          end else if (opcode_q == 8'h76) begin
            halt_d = 1'b1;
          end else if (opcode_q[7:6] == 2'b01) begin
            if (src != R_HL && dst != R_HL) begin
              rf_we    = 1'b1;
              rf_waddr = dst;
              rf_wdata = src_v;
            end
          end else if (opcode_q[7:6] == 2'b10) begin
            if (src != R_HL) begin
              flag_d   = alu_r.f;
              rf_we    = (dst != ALU_CP);
              rf_waddr = R_A;
              rf_wdata = alu_r.res;
            end
          end else if (opcode_q[7:6] == 2'b00 && opcode_q[2:1] == 2'b10) begin
            // INC r (bit0=0) / DEC r (bit0=1); carry is preserved
            if (dst != R_HL) begin
              rf_we          = 1'b1;
              rf_waddr       = dst;
              rf_wdata       = incdec_v;
              flag_d[FLAG_Z] = (incdec_v == 8'h00);
              flag_d[FLAG_N] = opcode_q[0];
              flag_d[FLAG_H] = opcode_q[0] ? (dst_v[3:0] == 4'h0) : (dst_v[3:0] == 4'hF);
            end
          end
`ifdef DEBUG_PORT_EN
          else if (opcode_q == 8'hD3) begin
            rf_we    = 1'b1;
            rf_waddr = R_A;
            rf_wdata = testing_data;
          end
`endif
        end
        T4: begin
          mcyc_d = (mcyc_q == M1 && is_ldn) ? M2 : M1;
          rd_d   = 1'b1;
          addr_d = pc_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tstate_q <= T1;
      mcyc_q   <= M1;
      pc_q     <= PC_RST;
      addr_q   <= 16'h0000;
      opcode_q <= 8'h00;
      imm_q    <= 8'h00;
      flag_q   <= 8'h00;
      dout_q   <= 8'h00;
      halt_q   <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      mcyc_q   <= mcyc_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      flag_q   <= flag_d;
      dout_q   <= dout_d;
      halt_q   <= halt_d;
      rd_q     <= rd_d;
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: directed programs with hand-computed register/flag/bus values.
module tb_cpu_top;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  testing_data = 8'h00;
  logic [7:0]  data_out;
  logic        rd;
  logic [15:0] addr_bus;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  prog[$];

  cpu_top dut (.clk(clk), .rst(rst), .testing_data(testing_data),
               .data_out(data_out), .rd(rd), .addr_bus(addr_bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.mem.mem[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) dut.mem.mem[i] = prog[i];
  endtask

  // Reset, load, release on a negedge; state is then M1/T1 at PC 0.
  task automatic boot();
    rst = 1'b0;
    load_prog();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  int cnt;

  initial begin
    // ---- reset and first program: LD B,08; LD A,B; ADD A,B
    prog = {8'h06, 8'h08, 8'h78, 8'h80};
    load_prog();
    #1;
    chk("rst_a", dut.r1.a.data_out, 8'h00);
    chk("rst_b", dut.r1.b.data_out, 8'h00);
    chk("rst_c", dut.r1.c.data_out, 8'h00);
    chk("rst_d", dut.r1.d.data_out, 8'h00);
    chk("rst_e", dut.r1.e.data_out, 8'h00);
    chk("rst_h", dut.r1.h.data_out, 8'h00);
    chk("rst_l", dut.r1.l.data_out, 8'h00);
    chk("rst_f", dut.flag_q, 8'h00);
    chk("rst_rd", rd, 1'b0);
    chk("rst_addr", addr_bus, 16'h0000);
    chk("rst_dout", data_out, 8'h00);
    #1 rst = 1'b1;
    #1;
    chk("first_m1t1", dut.m1t1, 1'b1);
    chk("first_addr", addr_bus, 16'h0000);
    step(1);
    chk("t2_dout", data_out, 8'h06);
    chk("t2_m1t1", dut.m1t1, 1'b0);
    step(3);
    chk("m2t1_m1t1", dut.m1t1, 1'b0);
    chk("m2t1_rd", rd, 1'b1);
    chk("m2t1_addr", addr_bus, 16'h0001);
    step(1);
    chk("m2t2_dout", data_out, 8'h08);
    step(2);
    chk("ldn_b", dut.r1.b.data_out, 8'h08);
    chk("t4_rd", rd, 1'b0);
    step(1);
    chk("next_m1t1", dut.m1t1, 1'b1);
    chk("next_addr", addr_bus, 16'h0002);
    step(4);
    chk("ld_ab", dut.r1.a.data_out, 8'h08);
    step(4);
    chk("add_a", dut.r1.a.data_out, 8'h10);
    chk("add_f", dut.flag_q, 8'h20);

    // ---- INC/DEC wrap and SUB borrow
    prog = {8'h06, 8'h08, 8'h3E, 8'hFF, 8'h3C, 8'h90, 8'h3C, 8'h05, 8'h0D};
    boot();
    step(16);
    chk("lda_ff", dut.r1.a.data_out, 8'hFF);
    step(4);
    chk("inc_wrap_a", dut.r1.a.data_out, 8'h00);
    chk("inc_wrap_f", dut.flag_q, 8'hA0);
    step(4);
    chk("sub_a", dut.r1.a.data_out, 8'hF8);
    chk("sub_f", dut.flag_q, 8'h70);
    step(4);
    chk("inc_keepc_a", dut.r1.a.data_out, 8'hF9);
    chk("inc_keepc_f", dut.flag_q, 8'h10);
    step(4);
    chk("dec_b", dut.r1.b.data_out, 8'h07);
    chk("dec_b_f", dut.flag_q, 8'h50);
    step(4);
    chk("dec_wrap_c", dut.r1.c.data_out, 8'hFF);
    chk("dec_wrap_f", dut.flag_q, 8'h70);

    // ---- logic ops, CP, ADC/SBC, (HL) operands
    prog = {8'h06, 8'h0F, 8'h3E, 8'h3C, 8'hA0, 8'hA8, 8'hB0, 8'hB8,
            8'h88, 8'h98, 8'h46, 8'h86};
    boot();
    step(20);
    chk("and_a", dut.r1.a.data_out, 8'h0C);
    chk("and_f", dut.flag_q, 8'h20);
    step(4);
    chk("xor_a", dut.r1.a.data_out, 8'h03);
    chk("xor_f", dut.flag_q, 8'h00);
    step(4);
    chk("or_a", dut.r1.a.data_out, 8'h0F);
    chk("or_f", dut.flag_q, 8'h00);
    step(4);
    chk("cp_a", dut.r1.a.data_out, 8'h0F);
    chk("cp_f", dut.flag_q, 8'hC0);
    step(4);
    chk("adc_a", dut.r1.a.data_out, 8'h1E);
    chk("adc_f", dut.flag_q, 8'h20);
    step(4);
    chk("sbc_a", dut.r1.a.data_out, 8'h0F);
    chk("sbc_f", dut.flag_q, 8'h60);
    step(4);
    chk("ld_b_hl", dut.r1.b.data_out, 8'h0F);
    step(4);
    chk("add_hl_a", dut.r1.a.data_out, 8'h0F);
    chk("add_hl_f", dut.flag_q, 8'h60);

    // ---- HALT
    prog = {8'h00, 8'h76};
    boot();
    step(7);
    chk("halt_pc", dut.pc_q, 16'h0002);
    chk("halt_rd", rd, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (dut.m1t1 || rd) cnt++;
    end
    chk("halt_no_fetch", cnt[15:0], 16'h0000);
    chk("halt_pc_hold", dut.pc_q, 16'h0002);
    chk("halt_addr", addr_bus, 16'h0001);

    // ---- debug port opcode
    prog = {8'hD3};
    testing_data = 8'h01;
    boot();
    step(4);
`ifdef DEBUG_PORT_EN
    chk("dbg_a", dut.r1.a.data_out, 8'h01);
`else
    chk("dbg_a", dut.r1.a.data_out, 8'h00);
`endif
    chk("dbg_f", dut.flag_q, 8'h00);
    chk("dbg_m1t1", dut.m1t1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
